// File: rtl/controle_varredura_sonar.sv
// -----------------------------------------------------------------------------
// controle_varredura_sonar
//
// Sequencer for the sonar sweep. It clears the position counter, waits a
// settling interval at each position, fires one distance measurement, latches
// the result and then advances the counter. While `ligar` is high the sweep
// runs continuously back and forth. The counter itself decides when to reverse
// direction; this block only pulses `conta_pos` once per position.
//
// Optional build feature:
//   CONTROLE_VARREDURA_TIMEOUT_EN - when defined, an unanswered measurement
//   gives up after T_TIMEOUT cycles in AGUARDA and goes through ERRO. When
//   undefined, AGUARDA waits forever and erro_medida is held at 0.
//
// Parameters:
//   T_ESPERA  - settling cycles at each position (>= 2)
//   T_TIMEOUT - max cycles waiting for medida_pronto (>= 2)
//   W_TIMER   - timer width, 2**W_TIMER > max(T_ESPERA, T_TIMEOUT)
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   ligar         in   level, 1 = sweep enabled
//   medida_pronto in   measurement done (sampled only in AGUARDA)
//   pos_fim       in   position counter is at its last position (M-1)
//   zera_pos      out  synchronous clear to the position counter
//   conta_pos     out  one-cycle count enable to the position counter
//   medir         out  one-cycle start pulse to the measurement unit
//   registra      out  one-cycle load enable for the result register
//   extremo       out  one-cycle pulse when advancing away from position M-1
//   erro_medida   out  one-cycle pulse on measurement timeout
//   db_estado     out  current state code (debug)
// -----------------------------------------------------------------------------
module controle_varredura_sonar #(
  parameter int T_ESPERA  = 25000000,
  parameter int T_TIMEOUT = 2000000,
  parameter int W_TIMER   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  input  logic       pos_fim,
  output logic       zera_pos,
  output logic       conta_pos,
  output logic       medir,
  output logic       registra,
  output logic       extremo,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ESPERA   = 4'd2,
    MEDE     = 4'd3,
    AGUARDA  = 4'd4,
    REGISTRA = 4'd5,
    AVANCA   = 4'd6,
    ERRO     = 4'd15
  } estado_t;

  localparam logic [W_TIMER-1:0] FIM_ESPERA  = W_TIMER'(T_ESPERA - 1);
`ifdef CONTROLE_VARREDURA_TIMEOUT_EN
  localparam logic [W_TIMER-1:0] FIM_TIMEOUT = W_TIMER'(T_TIMEOUT - 1);
`endif

  estado_t            estado;
  estado_t            proximo;
  logic [W_TIMER-1:0] timer;

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so every path drives proximo and no latch is inferred.
    proximo = estado;
    case (estado)
      INICIAL:  if (ligar) proximo = PREPARA;
      PREPARA:  proximo = ESPERA;
      ESPERA:   if (timer == FIM_ESPERA) proximo = MEDE;
      MEDE:     proximo = AGUARDA;
      AGUARDA: begin
        // A measurement that completes on the timeout cycle is still accepted.
        if (medida_pronto) begin
          proximo = REGISTRA;
        end
`ifdef CONTROLE_VARREDURA_TIMEOUT_EN
        else if (timer == FIM_TIMEOUT) begin
          proximo = ERRO;
        end
`endif
      end
      REGISTRA: proximo = ligar ? AVANCA : INICIAL;
      AVANCA:   proximo = ligar ? ESPERA : INICIAL;
      ERRO:     proximo = ligar ? AVANCA : INICIAL;
      default:  proximo = INICIAL;
    endcase
  end

  // State, timer and registered Moore outputs. Outputs are decoded from the
  // state being entered, so they line up with the state register cycle by
  // cycle without any combinational path from the inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: outputs are registers too, so reset clears them alongside the state.
      estado      <= INICIAL;
      timer       <= '0;
      zera_pos    <= 1'b0;
      conta_pos   <= 1'b0;
      medir       <= 1'b0;
      registra    <= 1'b0;
      extremo     <= 1'b0;
      erro_medida <= 1'b0;
      db_estado   <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      estado <= proximo;

      // Timer restarts on every transition and only counts in the waiting
      // states; both waits exit before it could wrap.
      if (proximo != estado) begin
        timer <= '0;
      end else if (estado == ESPERA || estado == AGUARDA) begin
        timer <= timer + W_TIMER'(1);
      end

      zera_pos  <= (proximo == PREPARA);
      conta_pos <= (proximo == AVANCA);
      medir     <= (proximo == MEDE);
      registra  <= (proximo == REGISTRA);
      // The counter does not move between REGISTRA/ERRO and AVANCA, so
      // pos_fim sampled on entry matches pos_fim during AVANCA.
      extremo   <= (proximo == AVANCA) && pos_fim;
`ifdef CONTROLE_VARREDURA_TIMEOUT_EN
      erro_medida <= (proximo == ERRO);
`else
      erro_medida <= 1'b0;
`endif
      db_estado <= proximo;
    end
  end

endmodule
